// File: rtl/my_mem_master_pkg.sv
// Shared types and helpers for my_mem_master: word geometry, FSM states and
// the even-parity word builder used to form 9-bit memory words.
package my_mem_master_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int WORD_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  // Memory word layout is {parity, data}; XOR across all 9 bits is 0 when valid.
  function automatic logic [WORD_WIDTH-1:0] even_parity(input logic [DATA_WIDTH-1:0] data);
    return {^data, data};
  endfunction

endpackage

// File: rtl/my_mem_master.sv
// Single-outstanding request controller for the parity-protected 9-bit memory.
// Optional build macro MY_MEM_MASTER_RETRY_EN re-reads once after a parity error.
module my_mem_master
  import my_mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_perr,
  output logic [CNT_WIDTH-1:0]  perr_count,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   parity_bad;

`ifdef MY_MEM_MASTER_RETRY_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  retried;
`endif

  assign parity_bad = ^mem_data_out;

  // Every output is a register updated alongside the state, so strobes line up
  // with the state they belong to and nothing is combinational from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      perr_count  <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
`ifdef MY_MEM_MASTER_RETRY_EN
      addr_q      <= '0;
      retried     <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_ready && req_valid) begin
            req_ready   <= 1'b0;
            mem_address <= req_addr;
`ifdef MY_MEM_MASTER_RETRY_EN
            addr_q      <= req_addr;
            retried     <= 1'b0;
`endif
            if (req_write) begin
              mem_write   <= 1'b1;
              mem_data_in <= req_wdata;
              state       <= ST_WRITE;
            end else begin
              mem_read <= 1'b1;
              state    <= ST_READ;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_WRITE: begin
          mem_write   <= 1'b0;
          mem_address <= '0;
          mem_data_in <= '0;
          rsp_rdata   <= '0;
          rsp_perr    <= 1'b0;
          rsp_valid   <= 1'b1;
          state       <= ST_RESP;
        end

        ST_READ: begin
          mem_read    <= 1'b0;
          mem_address <= '0;
          state       <= ST_CAPTURE;
        end

        // The memory word for the preceding read strobe is valid in this cycle.
        ST_CAPTURE: begin
`ifdef MY_MEM_MASTER_RETRY_EN
          if (parity_bad && !retried) begin
            retried     <= 1'b1;
            mem_read    <= 1'b1;
            mem_address <= addr_q;
            state       <= ST_READ;
          end else
`endif
          begin
            rsp_rdata <= mem_data_out[DATA_WIDTH-1:0];
            rsp_perr  <= parity_bad;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
            if (rsp_perr && (perr_count != {CNT_WIDTH{1'b1}}))
              perr_count <= perr_count + CNT_ONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_mem_master.sv
// Self-checking bench for my_mem_master: memory model, directed cases and
// randomized traffic checked against an address->byte reference map.
module tb_my_mem_master;
  import my_mem_master_pkg::*;

  localparam int AW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid, rsp_ready, rsp_perr;
  logic [7:0]    rsp_rdata;
  logic [CW-1:0] perr_count;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_data_in;
  logic [8:0]    mem_data_out = '0;

  always #5 clk = ~clk;

  my_mem_master #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_perr(rsp_perr), .perr_count(perr_count),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Memory: synchronous read, with the first inject_n reads after inject_base corrupted
  logic [8:0] mem_store [0:65535];
  int rd_total = 0;
  int inject_base = 0;
  int inject_n = 0;

  always @(posedge clk) begin
    if (mem_write) mem_store[mem_address] <= even_parity(mem_data_in);
    if (mem_read) begin
      if ((rd_total - inject_base) < inject_n)
        mem_data_out <= mem_store[mem_address] ^ 9'h100;
      else
        mem_data_out <= mem_store[mem_address];
      rd_total = rd_total + 1;
    end
  end

  int rd_seen = 0;
  int wr_seen = 0;
  int overlap = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [AW-1:0] last_rd_addr = '0;
  logic [7:0]    last_wr_data = '0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_seen = wr_seen + 1;
      last_wr_addr = mem_address;
      last_wr_data = mem_data_in;
    end
    if (mem_read) begin
      rd_seen = rd_seen + 1;
      last_rd_addr = mem_address;
    end
    if (mem_write && mem_read) overlap = overlap + 1;
  end

  logic [7:0] model_mem [int];
  int exp_count = 0;
  int tests_run = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [7:0] wd,
                               input int inject, input int bp);
    int waitc, edges, rd0, wr0, exp_lat, exp_rd;
    logic [7:0] exp_data;
    logic exp_perr;
    if (wr) begin
      exp_data = 8'h00; exp_perr = 1'b0; exp_lat = 1; exp_rd = 0;
    end else begin
      exp_data = model_mem.exists(int'(addr)) ? model_mem[int'(addr)] : 8'h00;
`ifdef MY_MEM_MASTER_RETRY_EN
      exp_perr = (inject >= 2);
      exp_rd   = (inject >= 1) ? 2 : 1;
      exp_lat  = (inject >= 1) ? 4 : 2;
`else
      exp_perr = (inject >= 1);
      exp_rd   = 1;
      exp_lat  = 2;
`endif
    end
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("req_ready_before_req", 32'(req_ready), 32'd1);
    if (req_ready !== 1'b1) return;
    rd0 = rd_seen; wr0 = wr_seen;
    inject_base = rd_total; inject_n = wr ? 0 : inject;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("rsp_latency", 32'(edges), 32'(exp_lat));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
    checkOutput("rsp_perr", 32'(rsp_perr), 32'(exp_perr));
    checkOutput("read_pulses", 32'(rd_seen - rd0), 32'(exp_rd));
    checkOutput("write_pulses", 32'(wr_seen - wr0), wr ? 32'd1 : 32'd0);
    if (wr) begin
      checkOutput("mem_data_in", 32'(last_wr_data), 32'(wd));
      checkOutput("mem_wr_address", 32'(last_wr_addr), 32'(addr));
      model_mem[int'(addr)] = wd;
    end else begin
      checkOutput("mem_rd_address", 32'(last_rd_addr), 32'(addr));
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
      checkOutput("bp_rsp_perr", 32'(rsp_perr), 32'(exp_perr));
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_perr && exp_count < 255) exp_count++;
    checkOutput("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
    checkOutput("perr_count", 32'(perr_count), 32'(exp_count));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int saw_rsp;
    for (int i = 0; i < 65536; i++) mem_store[i] = 9'h000;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset_perr_count", 32'(perr_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Directed: write, read-back, unwritten address, parity faults, backpressure
    applyStimulus(1'b1, 16'h0010, 8'hA5, 0, 0);
    applyStimulus(1'b0, 16'h0010, 8'h00, 0, 0);
    applyStimulus(1'b0, 16'h0200, 8'h00, 0, 0);
    applyStimulus(1'b0, 16'h0010, 8'h00, 1, 0);
    applyStimulus(1'b0, 16'h0010, 8'h00, 2, 0);
    applyStimulus(1'b0, 16'h0010, 8'h00, 0, 5);
    applyStimulus(1'b1, 16'hFFFF, 8'h3C, 0, 2);
    applyStimulus(1'b0, 16'hFFFF, 8'h00, 0, 0);

    // Reset in the middle of a read
    inject_n = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mid_read_strobe", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset_clears_perr_count", 32'(perr_count), 32'd0);
    exp_count = 0;
    saw_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp++;
    end
    checkOutput("no_rsp_after_reset", 32'(saw_rsp), 32'd0);
    applyStimulus(1'b0, 16'h0010, 8'h00, 0, 0);

    // Randomized traffic over a small address window so reads hit earlier writes
    for (int n = 0; n < 24; n++) begin
      logic wr;
      logic [AW-1:0] a;
      logic [7:0] d;
      wr = 1'($urandom_range(0, 1));
      a  = 16'h0100 + 16'($urandom_range(0, 7));
      d  = 8'($urandom);
      applyStimulus(wr, a, d, wr ? 0 : int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    checkOutput("strobe_overlap", 32'(overlap), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
